router_src_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single router input port (datain/packet_valid) between NUM_SRC packet sources.
- Grants one source for an entire packet (header, payload, parity) and pulls bytes from it.
- Drives the router's packet_valid framing and holds datain stable whenever the router asserts busy.
- Sits between the upstream packet buffers and router_top.

---
 rtl/router_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/router_src_arbiter.sv | 165 ++++++++++++++++
 tb/tb_router_src_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header field positions for the router packet datapath.
package router_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned HDR_LEN_MSB = 7;
  localparam int unsigned HDR_LEN_LSB = 2;
  localparam int unsigned LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int unsigned ADDR_W      = 2;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StPayload,
    StParity,
    StDrain
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, one-hot plus index.
module rr_arbiter #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx
);

  logic [NUM_SRC-1:0]   mask;
  logic [2*NUM_SRC-1:0] dbl;
  logic [2*NUM_SRC-1:0] dbl_pick;
  logic [2*NUM_SRC-1:0] one_w;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    one_w    = '0;
    one_w[0] = 1'b1;
    // Low half holds requests at/after ptr, high half wraps to the full vector.
    dbl      = {req, req & mask};
    dbl_pick = dbl & (~dbl + one_w);
    grant    = dbl_pick[NUM_SRC-1:0] | dbl_pick[2*NUM_SRC-1:NUM_SRC];
    grant_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) grant_idx = SRC_W'(i);
    end
  end

endmodule

// File: rtl/router_src_arbiter.sv
// Packet-level round-robin arbiter sharing the router input port between packet sources.
module router_src_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [BYTE_W*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_rd,
  output logic [NUM_SRC-1:0]        src_grant,
  input  logic                      busy,
  output logic [BYTE_W-1:0]         datain,
  output logic                      packet_valid,
  output logic [SRC_W-1:0]          cur_src,
  output logic                      pkt_done,
  output logic                      parity_err,
  output logic                      addr_err
);

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]    cur_q, cur_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   par_q, par_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                pv_q, pv_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic                perr_q, perr_d;
  logic                aerr_q, aerr_d;

  logic [NUM_SRC-1:0]  arb_grant;
  logic [SRC_W-1:0]    arb_idx;
  logic [BYTE_W-1:0]   sel;
  logic                load, consume, byte_st, rd_en;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_arbiter (
    .req       (src_req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Output register accepts a new byte when empty or when the router takes the current one.
  assign load    = !full_q || !busy;
  assign consume = full_q && !busy;
  assign byte_st = (state_q == StHeader) || (state_q == StPayload) || (state_q == StParity);
  assign rd_en   = load && byte_st;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_q == SRC_W'(i)) sel = src_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      data_q  <= '0;
      pv_q    <= 1'b0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      pv_q    <= pv_d;
      full_q  <= full_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      aerr_q  <= aerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (|src_req) state_d = StHeader;
      StHeader:  if (load) begin
        state_d = (sel[HDR_LEN_MSB:HDR_LEN_LSB] == '0) ? StParity : StPayload;
      end
      StPayload: if (load && (cnt_q == LEN_W'(1))) state_d = StParity;
      StParity:  if (load) state_d = StDrain;
      StDrain:   if (consume) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    data_d  = data_q;
    pv_d    = pv_q;
    full_d  = full_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    aerr_d  = 1'b0;
    src_rd  = rd_en ? grant_q : '0;

    if (consume) full_d = 1'b0;
    if (rd_en) begin
      full_d = 1'b1;
      data_d = sel;
    end

    case (state_q)
      StIdle: if (|src_req) begin
        grant_d = arb_grant;
        cur_d   = arb_idx;
      end
      StHeader: if (load) begin
        pv_d   = 1'b1;
        cnt_d  = sel[HDR_LEN_MSB:HDR_LEN_LSB];
        par_d  = sel;
        aerr_d = (sel[ADDR_W-1:0] == ADDR_INVALID);
      end
      StPayload: if (load) begin
        pv_d  = 1'b1;
        par_d = par_q ^ sel;
        cnt_d = cnt_q - LEN_W'(1);
      end
      StParity: if (load) begin
        pv_d   = 1'b0;
        perr_d = (sel != par_q);
      end
      StDrain: if (consume) begin
        done_d  = 1'b1;
        grant_d = '0;
        ptr_d   = (cur_q == SRC_W'(NUM_SRC - 1)) ? '0 : cur_q + SRC_W'(1);
      end
      default: ;
    endcase
  end

  assign src_grant    = grant_q;
  assign cur_src      = cur_q;
  assign datain       = data_q;
  assign packet_valid = pv_q;
  assign pkt_done     = done_q;
  assign parity_err   = perr_q;
  assign addr_err     = aerr_q;

endmodule

// File: tb/tb_router_src_arbiter.sv
// Randomized bench: FWFT source queues, router capture log and a round-robin grant model.
module tb_router_src_arbiter;

  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned SRC_W   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_SRC-1:0]   src_req;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_rd;
  logic [NUM_SRC-1:0]   src_grant;
  logic                 busy;
  logic [7:0]           datain;
  logic                 packet_valid;
  logic [SRC_W-1:0]     cur_src;
  logic                 pkt_done;
  logic                 parity_err;
  logic                 addr_err;

  router_src_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_req      (src_req),
    .src_data     (src_data),
    .src_rd       (src_rd),
    .src_grant    (src_grant),
    .busy         (busy),
    .datain       (datain),
    .packet_valid (packet_valid),
    .cur_src      (cur_src),
    .pkt_done     (pkt_done),
    .parity_err   (parity_err),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  // Source model: flat byte stream plus packet lengths (len+2) per source.
  logic [7:0] sbytes [NUM_SRC][$];
  int         plen   [NUM_SRC][$];
  int         bidx   [NUM_SRC];
  int         popcnt [NUM_SRC];

  logic [7:0] exp_pkt [$];
  logic [7:0] cap_b [$];
  logic       cap_v [$];
  int         grant_log [$];

  logic [NUM_SRC-1:0] req_prev;
  logic [NUM_SRC-1:0] prev_grant;
  bit pend;
  int mptr, active;
  int perr_cnt, aerr_cnt, pv_cycles;
  int last_pv_cycles, last_perr, last_aerr;
  int busy_pct, busy_force;
  int tests, fails;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_SRC-1:0] r, input int p);
    for (int k = 0; k < NUM_SRC; k++) begin
      int i;
      i = (p + k) % NUM_SRC;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic add_pkt(input int s, input int len, input logic [1:0] addr, input bit corrupt);
    logic [7:0] hdr, par, b;
    logic [5:0] l6;
    l6  = 6'(len);
    hdr = {l6, addr};
    par = hdr;
    sbytes[s].push_back(hdr);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      par ^= b;
      sbytes[s].push_back(b);
    end
    if (corrupt) par ^= 8'h01;
    sbytes[s].push_back(par);
    plen[s].push_back(len + 2);
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_req[i] = (plen[i].size() > 0);
      src_data[i*8 +: 8] = (sbytes[i].size() > 0) ? sbytes[i][0] : 8'h00;
    end
    if (busy_force > 0) begin
      busy = 1'b1;
      busy_force--;
    end else begin
      busy = ($urandom_range(0, 99) < busy_pct);
    end
  endtask

  task automatic tick();
    logic [7:0] d_hold;
    logic       v_hold;
    bit         hold, rst_edge;
    int         n, x;
    drive_sources();
    #1;
    hold     = 0;
    rst_edge = reset;
    d_hold   = '0;
    v_hold   = 1'b0;
    if (!rst_edge) begin
      if (pend && busy) begin
        check_val("busy_rd", src_rd, '0);
        hold   = 1;
        d_hold = datain;
        v_hold = packet_valid;
      end
      if (pend && !busy) begin
        cap_b.push_back(datain);
        cap_v.push_back(packet_valid);
      end
      if (src_rd != '0) begin
        check_val("rd_src", src_rd, (active >= 0) ? (32'd1 << active) : 32'd0);
        for (int i = 0; i < NUM_SRC; i++) begin
          if (src_rd[i]) begin
            check_val("rd_avail", (sbytes[i].size() > 0), 1'b1);
            if (sbytes[i].size() > 0) begin
              void'(sbytes[i].pop_front());
              popcnt[i]++;
              bidx[i]++;
              if (bidx[i] == plen[i][0]) begin
                void'(plen[i].pop_front());
                bidx[i] = 0;
              end
            end
          end
        end
        pend = 1;
      end else if (!busy) begin
        pend = 0;
      end
    end else begin
      pend = 0;
    end
    req_prev = src_req;
    @(posedge clk);
    @(negedge clk);
    if (rst_edge) begin
      prev_grant = src_grant;
      return;
    end
    if (hold) begin
      check_val("hold_data", datain, d_hold);
      check_val("hold_pv", packet_valid, v_hold);
    end
    if (prev_grant != '0 && !pkt_done) check_val("grant_hold", src_grant, prev_grant);
    if (src_grant != '0 && prev_grant == '0) begin
      int e;
      e = pick(req_prev, mptr);
      check_val("grant", src_grant, (e >= 0) ? (32'd1 << e) : 32'd0);
      check_val("cur_src", cur_src, e);
      active = e;
      grant_log.push_back(e);
      exp_pkt.delete();
      cap_b.delete();
      cap_v.delete();
      if (e >= 0) for (int k = 0; k < plen[e][0]; k++) exp_pkt.push_back(sbytes[e][k]);
      perr_cnt  = 0;
      aerr_cnt  = 0;
      pv_cycles = 0;
    end
    if (parity_err) perr_cnt++;
    if (addr_err) aerr_cnt++;
    if (packet_valid && active >= 0) pv_cycles++;
    if (pkt_done) begin
      check_val("done_pv", packet_valid, 1'b0);
      check_val("done_grant", src_grant, '0);
      check_val("cap_len", cap_b.size(), exp_pkt.size());
      n = (cap_b.size() < exp_pkt.size()) ? cap_b.size() : exp_pkt.size();
      for (int k = 0; k < n; k++) begin
        check_val("cap_byte", cap_b[k], exp_pkt[k]);
        check_val("cap_pv", cap_v[k], (k != exp_pkt.size() - 1));
      end
      if (exp_pkt.size() >= 2) begin
        x = 0;
        for (int k = 0; k < exp_pkt.size() - 1; k++) x ^= int'(exp_pkt[k]);
        check_val("parity_err", perr_cnt, (x != int'(exp_pkt[exp_pkt.size() - 1])));
        check_val("addr_err", aerr_cnt, (exp_pkt[0][1:0] == 2'b11));
      end
      last_pv_cycles = pv_cycles;
      last_perr      = perr_cnt;
      last_aerr      = aerr_cnt;
      if (active >= 0) mptr = (active + 1) % NUM_SRC;
      active = -1;
    end
    prev_grant = src_grant;
  endtask

  function automatic bit work_left();
    bit w;
    w = pend || (src_grant != '0);
    for (int i = 0; i < NUM_SRC; i++) if (plen[i].size() > 0) w = 1;
    return w;
  endfunction

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while (work_left() && n < max_cycles) begin
      tick();
      n++;
    end
    check_val("timeout", work_left(), 1'b0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rd"}, src_rd, '0);
    check_val({tag, "_grant"}, src_grant, '0);
    check_val({tag, "_datain"}, datain, '0);
    check_val({tag, "_pv"}, packet_valid, 1'b0);
    check_val({tag, "_cur"}, cur_src, '0);
    check_val({tag, "_done"}, pkt_done, 1'b0);
    check_val({tag, "_perr"}, parity_err, 1'b0);
    check_val({tag, "_aerr"}, addr_err, 1'b0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_SRC; i++) begin
      sbytes[i].delete();
      plen[i].delete();
      bidx[i]   = 0;
      popcnt[i] = 0;
    end
    exp_pkt.delete();
    cap_b.delete();
    cap_v.delete();
    pend   = 0;
    mptr   = 0;
    active = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sz, n;
    int exp_order [4] = '{0, 1, 2, 0};
    tests = 0; fails = 0;
    busy_pct = 0; busy_force = 0;
    prev_grant = '0; req_prev = '0;
    clear_model();
    reset = 1'b1; busy = 1'b0; src_req = '0; src_data = '0;
    @(negedge clk);
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // All three request from pointer 0: grants 0,1,2,0.
    sz = grant_log.size();
    add_pkt(0, 4, 2'b00, 0);
    add_pkt(0, 2, 2'b01, 0);
    add_pkt(1, 3, 2'b10, 0);
    add_pkt(2, 5, 2'b00, 0);
    run_until_idle(500);
    check_val("t2_count", grant_log.size() - sz, 4);
    for (int k = 0; k < 4; k++)
      if (sz + k < grant_log.size()) check_val("t2_order", grant_log[sz + k], exp_order[k]);

    // Header 0x51: len 20, addr 01.
    add_pkt(0, 20, 2'b01, 0);
    run_until_idle(200);
    check_val("t1_pv_run", last_pv_cycles, 21);
    check_val("t1_perr", last_perr, 0);

    // Header 0x02: zero-length payload.
    add_pkt(1, 0, 2'b10, 0);
    run_until_idle(100);
    check_val("t4_pv_run", last_pv_cycles, 1);
    check_val("t4_perr", last_perr, 0);

    // Corrupted parity, then invalid address 0x0F.
    add_pkt(2, 6, 2'b00, 1);
    run_until_idle(100);
    check_val("t5_perr", last_perr, 1);
    add_pkt(0, 3, 2'b11, 0);
    run_until_idle(100);
    check_val("t5_aerr", last_aerr, 1);
    check_val("t5_perr_clean", last_perr, 0);

    // Busy for 3 cycles right after payload byte 5 is loaded.
    add_pkt(0, 12, 2'b01, 0);
    base = popcnt[0];
    n = 0;
    while (popcnt[0] < base + 6 && n < 100) begin
      tick();
      n++;
    end
    check_val("t3_reach", popcnt[0] - base, 6);
    check_val("t3_b5_load", datain, (exp_pkt.size() > 5) ? exp_pkt[5] : 8'h00);
    busy_force = 3;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("t3_b5_hold", datain, (exp_pkt.size() > 5) ? exp_pkt[5] : 8'h00);
    end
    run_until_idle(200);

    // Random traffic with random busy, corruption and addresses.
    busy_pct = 30;
    for (int s = 0; s < NUM_SRC; s++)
      for (int p = 0; p < 5; p++)
        add_pkt(s, $urandom_range(0, 15), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    run_until_idle(3000);
    busy_pct = 0;

    // Reset during payload byte 10 from source 1.
    add_pkt(1, 20, 2'b00, 0);
    base = popcnt[1];
    n = 0;
    while (popcnt[1] < base + 11 && n < 100) begin
      tick();
      n++;
    end
    check_val("t6_reach", popcnt[1] - base, 11);
    reset = 1'b1;
    tick();
    check_reset_outputs("t6");
    clear_model();
    reset = 1'b0;
    tick();
    sz = grant_log.size();
    add_pkt(1, 2, 2'b00, 0);
    add_pkt(2, 2, 2'b01, 0);
    run_until_idle(200);
    check_val("t6_first", (grant_log.size() > sz) ? grant_log[sz] : -1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
